// File: rtl/wave_period_meter.sv
// Measures the period of a sampled waveform using hysteresis crossing detection,
// averaging 2^AVG_LOG consecutive periods and flagging loss of signal after TIMEOUT cycles.
//
//  state | meaning
//  IDLE  | no reference trigger yet (after reset or timeout); counter free-runs to TIMEOUT
//  MEAS  | reference trigger seen; accumulating periods between triggers
module wave_period_meter #(
  parameter int               W       = 6,
  parameter int               CNT_W   = 27,
  parameter logic [W-1:0]     LO_TH   = 6'd16,
  parameter logic [W-1:0]     HI_TH   = 6'd48,
  parameter int               AVG_LOG = 2,
  parameter logic [CNT_W-1:0] TIMEOUT = 27'd100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     sample,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             no_signal,
  output logic             locked
);

  localparam int ACC_W  = CNT_W + AVG_LOG;
  localparam int NPER_W = (AVG_LOG > 0) ? AVG_LOG : 1;
  localparam logic [NPER_W-1:0] NPER_LAST = NPER_W'((1 << AVG_LOG) - 1);

  typedef enum logic {IDLE, MEAS} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       s_q;
  logic               armed_q, armed_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [NPER_W-1:0]  nper_q, nper_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               period_valid_q, period_valid_d;
  logic               no_signal_q, no_signal_d;
  logic               locked_q, locked_d;

  logic               trig;
  logic               timeout;
  logic [ACC_W-1:0]   acc_sum;

  // s_q is a plain pipeline stage; armed_q is what reset clears.
  always_ff @(posedge clk) begin
    s_q <= sample;
    if (rst) begin
      state_q        <= IDLE;
      armed_q        <= 1'b0;
      count_q        <= '0;
      acc_q          <= '0;
      nper_q         <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      no_signal_q    <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      armed_q        <= armed_d;
      count_q        <= count_d;
      acc_q          <= acc_d;
      nper_q         <= nper_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      no_signal_q    <= no_signal_d;
      locked_q       <= locked_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    armed_d        = armed_q;
    count_d        = count_q;
    acc_d          = acc_q;
    nper_d         = nper_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    no_signal_d    = no_signal_q;
    locked_d       = locked_q;

    trig    = armed_q && (s_q >= HI_TH);
    timeout = !trig && (count_q >= TIMEOUT);
    acc_sum = acc_q + ACC_W'(count_q);

    // LO_TH < HI_TH, so disarm and re-arm can never coincide.
    if (trig) begin
      armed_d = 1'b0;
    end else if (s_q < LO_TH) begin
      armed_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d     = MEAS;
          count_d     = {{(CNT_W-1){1'b0}}, 1'b1};
          acc_d       = '0;
          nper_d      = '0;
          no_signal_d = 1'b0;
        end else if (timeout) begin
          no_signal_d = 1'b1;
          locked_d    = 1'b0;
          acc_d       = '0;
          nper_d      = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      MEAS: begin
        if (trig) begin
          count_d = {{(CNT_W-1){1'b0}}, 1'b1};
          if (nper_q == NPER_LAST) begin
            period_d       = CNT_W'(acc_sum >> AVG_LOG);
            period_valid_d = 1'b1;
            locked_d       = 1'b1;
            acc_d          = '0;
            nper_d         = '0;
          end else begin
            acc_d  = acc_sum;
            nper_d = nper_q + 1'b1;
          end
        end else if (timeout) begin
          state_d     = IDLE;
          no_signal_d = 1'b1;
          locked_d    = 1'b0;
          acc_d       = '0;
          nper_d      = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign no_signal    = no_signal_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_wave_period_meter.sv
// Bench for wave_period_meter: directed waveform scenarios plus randomized segments,
// checked every cycle against a trigger-timestamp reference model.
module tb_wave_period_meter;

  localparam int CNT_W = 27;
  localparam int N     = 4;
  localparam int TO    = 1000;
  localparam int LO    = 16;
  localparam int HI    = 48;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [5:0]       sample = 6'd0;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             no_signal;
  logic             locked;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  // stimulus entries are {rst, sample}
  logic [6:0] stim[$];

  // reference model: trigger timestamps since the last completed average
  int               m_q[$];
  int               m_ref;
  bit               m_armed;
  int               m_sreg;
  logic [CNT_W-1:0] m_period;
  bit               m_valid, m_nosig, m_locked;

  wave_period_meter #(
    .W(6), .CNT_W(CNT_W), .LO_TH(6'd16), .HI_TH(6'd48), .AVG_LOG(2),
    .TIMEOUT(27'd1000)
  ) dut (
    .clk(clk), .rst(rst), .sample(sample),
    .period(period), .period_valid(period_valid),
    .no_signal(no_signal), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    bit trig;
    m_valid = 1'b0;
    if (rst) begin
      m_q.delete();
      m_armed  = 1'b0;
      m_period = '0;
      m_nosig  = 1'b0;
      m_locked = 1'b0;
      m_ref    = edge_n + 1;
    end else begin
      trig = m_armed && (m_sreg >= HI);
      if (trig) begin
        m_armed = 1'b0;
        m_ref   = edge_n;
        m_nosig = 1'b0;
        m_q.push_back(edge_n);
        if (m_q.size() == N + 1) begin
          m_period = CNT_W'((m_q[N] - m_q[0]) / N);
          m_valid  = 1'b1;
          m_locked = 1'b1;
          m_q.delete();
          m_q.push_back(edge_n);
        end
      end else begin
        if (m_sreg < LO) m_armed = 1'b1;
        if (edge_n - m_ref >= TO) begin
          m_nosig  = 1'b1;
          m_locked = 1'b0;
          m_q.delete();
        end
      end
    end
    m_sreg = int'(sample);
  endtask

  task automatic tick(input logic [6:0] v);
    rst    = v[6];
    sample = v[5:0];
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
  endtask

  function automatic void add_level(input int v, input int n);
    for (int i = 0; i < n; i++) stim.push_back({1'b0, 6'(v)});
  endfunction

  function automatic void add_ramp(input int hold);
    for (int v = 0; v < 64; v++) add_level(v, hold);
  endfunction

  function automatic void add_dither_period();
    add_level(0, 20);
    for (int k = 0; k < 80; k++) stim.push_back({1'b0, (k % 2 == 0) ? 6'd49 : 6'd47});
  endfunction

  task automatic test_reset();
    stim.delete();
    for (int i = 0; i < 3; i++) stim.push_back(7'h40);
    foreach (stim[i]) begin
      tick(stim[i]);
      checks++;
      if ({period, period_valid, no_signal, locked} !== '0) begin
        failures++;
        $display("FAIL reset edge=%0d got p=%0d v=%b ns=%b lk=%b required all zero",
                 edge_n, period, period_valid, no_signal, locked);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_ramp_fast();
    int e_s, first_v, last_v, nvalid;
    stim.delete();
    for (int r = 0; r < 10; r++) add_ramp(1);
    e_s = edge_n; first_v = -1; last_v = -1; nvalid = 0;
    foreach (stim[i]) begin
      tick(stim[i]);
      checks++;
      if ({period, period_valid, no_signal, locked} !== {m_period, m_valid, m_nosig, m_locked}) begin
        failures++;
        $display("FAIL ramp_fast edge=%0d got p=%0d v=%b ns=%b lk=%b exp p=%0d v=%b ns=%b lk=%b",
                 edge_n, period, period_valid, no_signal, locked, m_period, m_valid, m_nosig, m_locked);
      end
      if (period_valid === 1'b1) begin
        if (first_v < 0) first_v = edge_n;
        if (last_v >= 0) begin
          checks++;
          if (edge_n - last_v !== 256) begin
            failures++;
            $display("FAIL ramp_fast_spacing got %0d required 256", edge_n - last_v);
          end
        end
        last_v = edge_n;
        nvalid++;
      end
    end
    checks++;
    if (first_v !== e_s + 50 + 256) begin
      failures++;
      $display("FAIL ramp_fast_first_valid got edge %0d required %0d", first_v, e_s + 306);
    end
    checks++;
    if ({period, locked, nvalid} !== {27'd64, 1'b1, 32'd2}) begin
      failures++;
      $display("FAIL ramp_fast_final got p=%0d lk=%b n=%0d required p=64 lk=1 n=2", period, locked, nvalid);
    end
  endtask

  task automatic test_ramp_slow();
    int split, nfast, fast_second;
    logic [CNT_W-1:0] slow_last;
    bit saw_nosig;
    stim.delete();
    for (int r = 0; r < 9; r++) add_ramp(10);
    split = stim.size();
    for (int r = 0; r < 10; r++) add_ramp(5);
    nfast = 0; fast_second = -1; slow_last = '0; saw_nosig = 1'b0;
    foreach (stim[i]) begin
      tick(stim[i]);
      checks++;
      if ({period, period_valid, no_signal, locked} !== {m_period, m_valid, m_nosig, m_locked}) begin
        failures++;
        $display("FAIL ramp_slow edge=%0d got p=%0d v=%b ns=%b lk=%b exp p=%0d v=%b ns=%b lk=%b",
                 edge_n, period, period_valid, no_signal, locked, m_period, m_valid, m_nosig, m_locked);
      end
      if (no_signal !== 1'b0) saw_nosig = 1'b1;
      if (period_valid === 1'b1) begin
        if (i < split) slow_last = period;
        else begin
          nfast++;
          if (nfast == 2) fast_second = int'(period);
        end
      end
    end
    checks++;
    if (slow_last !== 27'd640) begin
      failures++;
      $display("FAIL ramp_slow_640 got %0d required 640", slow_last);
    end
    checks++;
    if (fast_second !== 320) begin
      failures++;
      $display("FAIL ramp_switch_320 got %0d required 320", fast_second);
    end
    checks++;
    if (saw_nosig !== 1'b0) begin
      failures++;
      $display("FAIL ramp_no_signal got 1 required 0");
    end
  endtask

  task automatic test_alternate();
    stim.delete();
    for (int r = 0; r < 6; r++) begin
      add_level(0, 50); add_level(63, 50);
      add_level(0, 52); add_level(63, 52);
    end
    foreach (stim[i]) begin
      tick(stim[i]);
      checks++;
      if ({period, period_valid, no_signal, locked} !== {m_period, m_valid, m_nosig, m_locked}) begin
        failures++;
        $display("FAIL alternate edge=%0d got p=%0d v=%b ns=%b lk=%b exp p=%0d v=%b ns=%b lk=%b",
                 edge_n, period, period_valid, no_signal, locked, m_period, m_valid, m_nosig, m_locked);
      end
    end
    checks++;
    if ({period, locked} !== {27'd102, 1'b1}) begin
      failures++;
      $display("FAIL alternate_102 got p=%0d lk=%b required p=102 lk=1", period, locked);
    end
  endtask

  task automatic test_timeout();
    int e_s, i_h, ns_edge, stuck_at;
    bit stray_valid;
    stim.delete();
    for (int r = 0; r < 9; r++) begin add_level(0, 50); add_level(63, 50); end
    stuck_at = stim.size();
    add_level(0, 1200);
    i_h = 8 * 100 + 50;
    e_s = edge_n; ns_edge = -1; stray_valid = 1'b0;
    foreach (stim[i]) begin
      tick(stim[i]);
      checks++;
      if ({period, period_valid, no_signal, locked} !== {m_period, m_valid, m_nosig, m_locked}) begin
        failures++;
        $display("FAIL timeout edge=%0d got p=%0d v=%b ns=%b lk=%b exp p=%0d v=%b ns=%b lk=%b",
                 edge_n, period, period_valid, no_signal, locked, m_period, m_valid, m_nosig, m_locked);
      end
      if (i == stuck_at - 1) begin
        checks++;
        if ({period, locked} !== {27'd100, 1'b1}) begin
          failures++;
          $display("FAIL timeout_prelock got p=%0d lk=%b required p=100 lk=1", period, locked);
        end
      end
      if (i >= stuck_at && period_valid === 1'b1) stray_valid = 1'b1;
      if (ns_edge < 0 && no_signal === 1'b1) ns_edge = edge_n;
    end
    // last trigger is evaluated one edge after the final high sample is registered
    checks++;
    if (ns_edge !== e_s + i_h + 2 + TO) begin
      failures++;
      $display("FAIL timeout_edge got %0d required %0d", ns_edge, e_s + i_h + 2 + TO);
    end
    checks++;
    if ({period, no_signal, locked, stray_valid} !== {27'd100, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL timeout_state got p=%0d ns=%b lk=%b stray_v=%b required p=100 ns=1 lk=0 stray_v=0",
               period, no_signal, locked, stray_valid);
    end
  endtask

  task automatic test_dither_reset();
    int i_rst, nvalid;
    stim.delete();
    for (int r = 0; r < 8; r++) add_dither_period();
    add_level(0, 20);
    for (int k = 0; k < 30; k++) stim.push_back({1'b0, (k % 2 == 0) ? 6'd49 : 6'd47});
    i_rst = stim.size();
    stim.push_back({1'b1, 6'd49});
    for (int r = 0; r < 5; r++) add_dither_period();
    nvalid = 0;
    foreach (stim[i]) begin
      tick(stim[i]);
      checks++;
      if ({period, period_valid, no_signal, locked} !== {m_period, m_valid, m_nosig, m_locked}) begin
        failures++;
        $display("FAIL dither edge=%0d got p=%0d v=%b ns=%b lk=%b exp p=%0d v=%b ns=%b lk=%b",
                 edge_n, period, period_valid, no_signal, locked, m_period, m_valid, m_nosig, m_locked);
      end
      if (i > i_rst && period_valid === 1'b1) nvalid++;
      if (i == i_rst - 1) begin
        checks++;
        if ({period, no_signal, locked} !== {27'd100, 1'b0, 1'b1}) begin
          failures++;
          $display("FAIL dither_period got p=%0d ns=%b lk=%b required p=100 ns=0 lk=1", period, no_signal, locked);
        end
      end
      if (i == i_rst) begin
        checks++;
        if ({period, period_valid, no_signal, locked} !== '0) begin
          failures++;
          $display("FAIL dither_reset got p=%0d v=%b ns=%b lk=%b required all zero",
                   period, period_valid, no_signal, locked);
        end
      end
      if (i == i_rst + 400) begin
        checks++;
        if ({locked, nvalid} !== {1'b0, 32'd0}) begin
          failures++;
          $display("FAIL dither_early_lock got lk=%b n=%0d required lk=0 n=0", locked, nvalid);
        end
      end
    end
    checks++;
    if ({period, locked, nvalid} !== {27'd100, 1'b1, 32'd1}) begin
      failures++;
      $display("FAIL dither_relock got p=%0d lk=%b n=%0d required p=100 lk=1 n=1", period, locked, nvalid);
    end
  endtask

  task automatic test_random();
    int n;
    stim.delete();
    for (int seg = 0; seg < 40; seg++) begin
      if ($urandom_range(0, 9) < 8) begin
        n = $urandom_range(3, 60);
        for (int k = 0; k < n; k++) stim.push_back({1'b0, 6'($urandom_range(0, 15))});
        n = $urandom_range(0, 20);
        for (int k = 0; k < n; k++) stim.push_back({1'b0, 6'($urandom_range(16, 47))});
        n = $urandom_range(3, 60);
        for (int k = 0; k < n; k++) stim.push_back({1'b0, 6'($urandom_range(48, 63))});
        n = $urandom_range(0, 20);
        for (int k = 0; k < n; k++) stim.push_back({1'b0, 6'($urandom_range(16, 63))});
      end else begin
        add_level($urandom_range(0, 63), $urandom_range(900, 1100));
      end
      if ($urandom_range(0, 19) == 0) begin
        n = $urandom_range(1, 2);
        for (int k = 0; k < n; k++) stim.push_back({1'b1, 6'($urandom_range(0, 63))});
      end
    end
    stim.push_back(7'd0);
    foreach (stim[i]) begin
      tick(stim[i]);
      checks++;
      if ({period, period_valid, no_signal, locked} !== {m_period, m_valid, m_nosig, m_locked}) begin
        failures++;
        $display("FAIL random edge=%0d got p=%0d v=%b ns=%b lk=%b exp p=%0d v=%b ns=%b lk=%b",
                 edge_n, period, period_valid, no_signal, locked, m_period, m_valid, m_nosig, m_locked);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_q.delete();
    m_ref = 0; m_armed = 1'b0; m_sreg = 0;
    m_period = '0; m_valid = 1'b0; m_nosig = 1'b0; m_locked = 1'b0;
    test_reset();
    test_ramp_fast();
    test_ramp_slow();
    test_alternate();
    test_timeout();
    test_dither_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
